// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, decode and the register
// file write port. The arbiter uses the slave view; sources/decode drive the
// master view.
interface rf_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    // EXU writeback requester
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;
    // LSU writeback requester
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;
    // issue / hazard check
    logic                  iss_valid;
    logic [ADDR_WIDTH-1:0] iss_addr;
    logic [ADDR_WIDTH-1:0] chk_addr1;
    logic [ADDR_WIDTH-1:0] chk_addr2;
    logic                  busy1;
    logic                  busy2;
    // register file write port
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    // statistics
    logic [31:0]           conflict_cnt;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        input  iss_valid, iss_addr, chk_addr1, chk_addr2,
        output busy1, busy2,
        output rf_wen, rf_waddr, rf_wdata,
        output conflict_cnt
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        output iss_valid, iss_addr, chk_addr1, chk_addr2,
        input  busy1, busy2,
        input  rf_wen, rf_waddr, rf_wdata,
        input  conflict_cnt
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between EXU
// (port 0) and LSU (port 1), with a one-cycle registered write stage and a
// per-register pending scoreboard for decode hazard detection.
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,    // asynchronous, active-low
    rf_wb_arbiter_if.slave     bus
);
    localparam int NREG = 1 << ADDR_WIDTH;

    // grant and selected transfer
    logic                  gnt0_s;
    logic                  gnt1_s;
    logic                  xfer_s;
    logic [ADDR_WIDTH-1:0] xfer_addr_s;
    logic [DATA_WIDTH-1:0] xfer_data_s;
    logic                  iss_set_s;

    // state
    logic                  last_grant_q, last_grant_d;
    logic                  rf_wen_q,     rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q,   rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q,   rf_wdata_d;
    logic [NREG-1:0]       pend_q,       pend_d;
    logic [31:0]           conflict_q,   conflict_d;

    // Grant: a lone requester wins; on contention the port not served last wins
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            if (last_grant_q) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (bus.req0_valid) begin
            gnt0_s = 1'b1;
        end else if (bus.req1_valid) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Select the address/data of the accepted request (grant implies valid)
    always_comb begin
        xfer_s      = gnt0_s | gnt1_s;
        xfer_addr_s = {ADDR_WIDTH{1'b0}};
        xfer_data_s = {DATA_WIDTH{1'b0}};
        if (gnt0_s) begin
            xfer_addr_s = bus.req0_addr;
            xfer_data_s = bus.req0_data;
        end else if (gnt1_s) begin
            xfer_addr_s = bus.req1_addr;
            xfer_data_s = bus.req1_data;
        end else begin
            xfer_addr_s = {ADDR_WIDTH{1'b0}};
            xfer_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Next-state: round-robin pointer, write stage, scoreboard, conflict counter
    always_comb begin
        last_grant_d = last_grant_q;
        rf_wen_d     = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        pend_d       = pend_q;
        conflict_d   = conflict_q;
        iss_set_s    = bus.iss_valid && (bus.iss_addr != {ADDR_WIDTH{1'b0}});

        if (gnt1_s) begin
            last_grant_d = 1'b1;
        end else if (gnt0_s) begin
            last_grant_d = 1'b0;
        end else begin
            last_grant_d = last_grant_q;
        end

        // x0 writes are accepted but never reach the register file
        if (xfer_s) begin
            rf_wen_d            = (xfer_addr_s != {ADDR_WIDTH{1'b0}});
            rf_waddr_d          = xfer_addr_s;
            rf_wdata_d          = xfer_data_s;
            pend_d[xfer_addr_s] = 1'b0;
        end else begin
            rf_wen_d   = 1'b0;
            rf_waddr_d = rf_waddr_q;
            rf_wdata_d = rf_wdata_q;
        end

        // applied after the clear so a same-edge reissue stays outstanding
        if (iss_set_s) begin
            pend_d[bus.iss_addr] = 1'b1;
        end else begin
            pend_d = pend_d;
        end

        if (bus.req0_valid && bus.req1_valid && (conflict_q != 32'hFFFF_FFFF)) begin
            conflict_d = conflict_q + 32'd1;
        end else begin
            conflict_d = conflict_q;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= {ADDR_WIDTH{1'b0}};
            rf_wdata_q   <= {DATA_WIDTH{1'b0}};
            pend_q       <= {NREG{1'b0}};
            conflict_q   <= 32'd0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            pend_q       <= pend_d;
            conflict_q   <= conflict_d;
        end
    end

    assign bus.req0_ready   = gnt0_s;
    assign bus.req1_ready   = gnt1_s;
    assign bus.busy1        = pend_q[bus.chk_addr1] & (bus.chk_addr1 != {ADDR_WIDTH{1'b0}});
    assign bus.busy2        = pend_q[bus.chk_addr2] & (bus.chk_addr2 != {ADDR_WIDTH{1'b0}});
    assign bus.rf_wen       = rf_wen_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.conflict_cnt = conflict_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter. Register-file writes are predicted
// by a reference model and queued; a monitor compares them after each edge.
module tb_rf_wb_arbiter;
    localparam int AW = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    rf_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // reference model
    wr_t           exp_q[$];
    wr_t           mon_e;
    logic          m_last;
    logic [15:0]   m_pend;
    logic [31:0]   m_cnt;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;

    function automatic int exp_grant();
        if (bus.req0_valid && bus.req1_valid) return m_last ? 0 : 1;
        else if (bus.req0_valid) return 0;
        else if (bus.req1_valid) return 1;
        else return 2;
    endfunction

    // monitor: compare predicted write port contents after every edge
    always @(posedge clk) begin
        #1;
        if (rst && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            if (bus.rf_wen !== mon_e.wen) begin
                n_fail++;
                $display("FAIL rf_wen: got %b expected %b at %0t", bus.rf_wen, mon_e.wen, $time);
            end
            n_tests++;
            if (bus.rf_waddr !== mon_e.addr) begin
                n_fail++;
                $display("FAIL rf_waddr: got %0d expected %0d at %0t", bus.rf_waddr, mon_e.addr, $time);
            end
            n_tests++;
            if (bus.rf_wdata !== mon_e.data) begin
                n_fail++;
                $display("FAIL rf_wdata: got %h expected %h at %0t", bus.rf_wdata, mon_e.data, $time);
            end
        end
    end

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        bus.iss_valid  = 1'b0; bus.iss_addr  = '0;
        bus.chk_addr1  = '0;   bus.chk_addr2 = '0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last = 1'b1; m_pend = '0; m_cnt = '0; m_wa = '0; m_wd = '0;
    endtask

    // one clock: predict from current inputs, queue expectation, advance
    task automatic tick();
        int  g;
        wr_t e;
        g = exp_grant();
        if (g == 0) begin
            e.wen = (bus.req0_addr != '0); e.addr = bus.req0_addr; e.data = bus.req0_data;
            m_last = 1'b0; m_pend[bus.req0_addr] = 1'b0;
            m_wa = bus.req0_addr; m_wd = bus.req0_data;
        end else if (g == 1) begin
            e.wen = (bus.req1_addr != '0); e.addr = bus.req1_addr; e.data = bus.req1_data;
            m_last = 1'b1; m_pend[bus.req1_addr] = 1'b0;
            m_wa = bus.req1_addr; m_wd = bus.req1_data;
        end else begin
            e.wen = 1'b0; e.addr = m_wa; e.data = m_wd;
        end
        if (bus.iss_valid && bus.iss_addr != '0) m_pend[bus.iss_addr] = 1'b1;
        if (bus.req0_valid && bus.req1_valid && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b expected 0", bus.rf_wen); end
        n_tests++;
        if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b%b expected 00", bus.busy1, bus.busy2);
        end
        n_tests++;
        if (bus.conflict_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bus.conflict_cnt); end
        bus.req0_valid = 1'b1;
        #1;
        n_tests++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b%b expected 01", bus.req1_ready, bus.req0_ready);
        end
        bus.req0_valid = 1'b0;
        #1;
    endtask

    task automatic test_single_write();
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd5; bus.req0_data = 32'h0000_1234;
        #1;
        n_tests++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL single_ready: got %b%b expected 01", bus.req1_ready, bus.req0_ready);
        end
        tick();
        bus.req0_valid = 1'b0;
        n_tests++;
        if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 4'd5 || bus.rf_wdata !== 32'h0000_1234) begin
            n_fail++; $display("FAIL single_write: got wen=%b addr=%0d data=%h expected 1/5/00001234",
                               bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
        end
        tick();
        n_tests++;
        if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL single_wen_drop: got %b expected 0", bus.rf_wen); end
    endtask

    task automatic test_round_robin();
        int pat[4] = '{0, 1, 0, 1};
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd1; bus.req0_data = 32'hA000_0001;
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd2; bus.req1_data = 32'hB000_0002;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (bus.req0_ready !== (pat[i] == 0) || bus.req1_ready !== (pat[i] == 1)) begin
                n_fail++; $display("FAIL rr_grant%0d: got r1r0=%b%b expected port %0d",
                                   i, bus.req1_ready, bus.req0_ready, pat[i]);
            end
            tick();
            // granted requester moves on to a fresh request
            if (pat[i] == 0) begin
                bus.req0_addr = bus.req0_addr + 4'd2; bus.req0_data = bus.req0_data + 32'd1;
            end else begin
                bus.req1_addr = bus.req1_addr + 4'd2; bus.req1_data = bus.req1_data + 32'd1;
            end
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        n_tests++;
        if (bus.conflict_cnt !== 32'd4) begin n_fail++; $display("FAIL rr_cnt: got %0d expected 4", bus.conflict_cnt); end
        tick();
    endtask

    task automatic test_scoreboard();
        bus.iss_valid = 1'b1; bus.iss_addr = 4'd10;
        tick();
        bus.iss_valid = 1'b0; bus.chk_addr1 = 4'd10;
        #1;
        n_tests++;
        if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_busy_set: got %b expected 1", bus.busy1); end
        tick();
        tick();
        n_tests++;
        if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_busy_hold: got %b expected 1", bus.busy1); end
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd10; bus.req1_data = 32'hDEAD_BEEF;
        #1;
        n_tests++;
        if (bus.busy1 !== 1'b1 || bus.req1_ready !== 1'b1) begin
            n_fail++; $display("FAIL sb_busy_at_xfer: got busy=%b ready=%b expected 1/1", bus.busy1, bus.req1_ready);
        end
        tick();
        bus.req1_valid = 1'b0;
        #1;
        n_tests++;
        if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_busy_clear: got %b expected 0", bus.busy1); end
        tick();
    endtask

    task automatic test_set_clear_same();
        bus.iss_valid = 1'b1; bus.iss_addr = 4'd7;
        tick();
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd7; bus.req0_data = 32'h7777_0001;
        tick();
        bus.iss_valid = 1'b0; bus.req0_valid = 1'b0; bus.chk_addr2 = 4'd7;
        #1;
        n_tests++;
        if (bus.busy2 !== 1'b1) begin n_fail++; $display("FAIL setclr_same: got %b expected 1", bus.busy2); end
        bus.iss_valid = 1'b1; bus.iss_addr = 4'd3;
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd7; bus.req0_data = 32'h7777_0002;
        tick();
        bus.iss_valid = 1'b0; bus.req0_valid = 1'b0; bus.chk_addr1 = 4'd3;
        #1;
        n_tests++;
        if (bus.busy1 !== 1'b1 || bus.busy2 !== 1'b0) begin
            n_fail++; $display("FAIL setclr_diff: got busy1=%b busy2=%b expected 1/0", bus.busy1, bus.busy2);
        end
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd3; bus.req1_data = 32'h3333_0003;
        tick();
        bus.req1_valid = 1'b0;
        #1;
        n_tests++;
        if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL setclr_release: got %b expected 0", bus.busy1); end
    endtask

    task automatic test_addr_zero();
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd0; bus.req1_data = 32'h0BAD_0000;
        bus.iss_valid = 1'b1; bus.iss_addr = 4'd0;
        #1;
        n_tests++;
        if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b expected 1", bus.req1_ready); end
        tick();
        bus.req1_valid = 1'b0; bus.iss_valid = 1'b0;
        bus.chk_addr1 = 4'd0; bus.chk_addr2 = 4'd0;
        #1;
        n_tests++;
        if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL zero_wen: got %b expected 0", bus.rf_wen); end
        n_tests++;
        if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin
            n_fail++; $display("FAIL zero_busy: got %b%b expected 00", bus.busy1, bus.busy2);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.iss_valid = 1'b1; bus.iss_addr = 4'd9;
        tick();
        bus.iss_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd4; bus.req0_data = 32'h4444_4444;
        bus.chk_addr1 = 4'd9;
        tick();
        bus.req0_valid = 1'b0;
        n_tests++;
        if (bus.rf_wen !== 1'b1 || bus.busy1 !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre: got wen=%b busy=%b expected 1/1", bus.rf_wen, bus.busy1);
        end
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL mid_wen_async: got %b expected 0", bus.rf_wen); end
        n_tests++;
        if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL mid_pend_clear: got %b expected 0", bus.busy1); end
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd6; bus.req0_data = 32'h6666_0006;
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd8; bus.req1_data = 32'h8888_0008;
        #1;
        n_tests++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_next_grant: got r1r0=%b%b expected 01", bus.req1_ready, bus.req0_ready);
        end
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tick();
        n_tests++;
        if (bus.conflict_cnt !== 32'd1) begin n_fail++; $display("FAIL mid_cnt: got %0d expected 1", bus.conflict_cnt); end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_single_write();
        test_round_robin();
        test_scoreboard();
        test_set_clear_same();
        test_addr_zero();
        test_reset_mid();
        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d queued expected 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: port 0 is EXU/ALU results, port 1 is LSU load data.
- Uses round-robin arbitration with valid/ready handshakes and a registered write-port stage.
- Keeps a per-register pending scoreboard so decode can detect read-after-write hazards on both read addresses.
- Sits between the writeback sources and the register file's wen/waddr/wdata inputs.

Parameters:
ADDR_WIDTH, 4, register index width (16 registers, RV32E)
DATA_WIDTH, 32, register data width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
req0_valid  input  1  EXU writeback request
req0_addr  input  ADDR_WIDTH  EXU destination register
req0_data  input  DATA_WIDTH  EXU result
req0_ready  output  1  EXU request granted this cycle
req1_valid  input  1  LSU writeback request
req1_addr  input  ADDR_WIDTH  LSU destination register
req1_data  input  DATA_WIDTH  LSU load data
req1_ready  output  1  LSU request granted this cycle
iss_valid  input  1  instruction issued with a destination register
iss_addr  input  ADDR_WIDTH  destination of issued instruction
chk_addr1  input  ADDR_WIDTH  decode source register 1
chk_addr2  input  ADDR_WIDTH  decode source register 2
busy1  output  1  chk_addr1 has a write pending
busy2  output  1  chk_addr2 has a write pending
rf_wen  output  1  to register file wen
rf_waddr  output  ADDR_WIDTH  to register file waddr
rf_wdata  output  DATA_WIDTH  to register file wdata
conflict_cnt  output  32  saturating count of cycles with both requests valid

Behaviour:
- Reset (rst=0, asynchronous): rf_wen=0, rf_waddr=0, rf_wdata=0, pend[] all 0, last_grant=1, conflict_cnt=0. Any in-flight write is discarded.
- Outputs after reset: ready outputs and busy outputs are combinational and evaluate to 0 while no requests or pending bits exist.
- Grant rules (combinational):
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant the port opposite to last_grant.
  - Neither valid: no grant.
  - reqN_ready = grant==N. At most one ready is high per cycle.
  - Ready does not depend on the requester's own valid beyond the grant rules above.
- Handshake: a transfer occurs when reqN_valid & reqN_ready.
  - On a transfer, last_grant <= N.
  - With no transfer, last_grant holds.
  - A requester holds valid/addr/data stable until it is accepted.
- Write stage (1-cycle latency): on a transfer in cycle T, in cycle T+1 rf_wen=(addr!=0), rf_waddr=addr, rf_wdata=data.
  - With no transfer in T, rf_wen=0 in T+1; waddr and wdata hold their last values.
  - An addr=0 transfer is accepted but never produces rf_wen=1.
- Scoreboard:
  - iss_valid & iss_addr!=0 sets pend[iss_addr] at the clock edge.
  - A transfer with addr A clears pend[A] at the same edge.
  - Set and clear of the same address on the same edge: set wins, because the newer issue is outstanding.
  - Set and clear of different addresses: both take effect.
- Busy outputs: busyK = pend[chk_addrK] & (chk_addrK!=0), combinational from registered pend.
  - No bypass: a register stays busy until the edge after its transfer.
  - The register file sees the data one further cycle later; decode therefore waits at least one cycle after busy drops.
  - The register file's own read path covers that cycle.
- conflict_cnt increments every cycle with req0_valid & req1_valid, and saturates at 32'hFFFF_FFFF.
- Transfers to registers with no pending bit are legal and produce no scoreboard change.

Test Plan:
- Reset with rst=0 for 2 cycles, then release → rf_wen=0, busy1=busy2=0, conflict_cnt=0, req0_ready=1 as soon as req0_valid=1 alone.
- req0 {addr=5, data=0x1234} alone in cycle T → req0_ready=1 in T; rf_wen=1, rf_waddr=5, rf_wdata=0x1234 in T+1; rf_wen=0 in T+2.
- Both valid for 4 cycles with no prior grant → grants 0,1,0,1; conflict_cnt=4 afterwards.
- iss_valid with iss_addr=10, then chk_addr1=10 → busy1=1 until the edge where a port accepts addr=10; busy1=0 on the following cycle.
- Same edge has iss_addr=7 and an accepted write to 7 → pend[7] stays 1 and busy remains asserted.
- req1 write to addr 0 → accepted with req1_ready=1, rf_wen stays 0; iss_addr=0 never sets busy.
- Reset asserted mid-transfer → rf_wen drops to 0 asynchronously, pending bits cleared, and the next grant goes to port 0.
